// File: rtl/spart_core.sv
// Bus-mapped 8N1 UART: divisor-driven 16x baud enable, TX shifter, RX sampler, tbr/rda status.
// Define SPART_LOOPBACK_EN to feed the internal txd into the RX synchronizer instead of the rxd pin.
module spart_core #(
  parameter logic [15:0] DIV_RESET = 16'd1302
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  logic        wr_en, rd_en;
  logic        wr_tx, wr_dlo, wr_dhi, rd_rx, rd_st;
  logic [15:0] div_q, div_d;
  logic [15:0] cnt_q, cnt_d;
  logic        en16;
  logic [7:0]  rd_data;
  logic        rx_in;

  tx_state_e   tx_state_q;
  logic [3:0]  tx_tick_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_shift_q;
  logic        tbr_q;
  logic        txd_q;

  rx_state_e   rx_state_q;
  logic        rx_s1_q, rx_s2_q;
  logic [3:0]  rx_tick_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_shift_q;
  logic [7:0]  rx_buf_q;
  logic        rda_q, ovr_q, ferr_q;

  assign wr_en  = iocs & ~iorw;
  assign rd_en  = iocs & iorw;
  assign wr_tx  = wr_en && (ioaddr == 2'b00);
  assign wr_dlo = wr_en && (ioaddr == 2'b10);
  assign wr_dhi = wr_en && (ioaddr == 2'b11);
  assign rd_rx  = rd_en && (ioaddr == 2'b00);
  assign rd_st  = rd_en && (ioaddr == 2'b01);

`ifdef SPART_LOOPBACK_EN
  logic unused_rxd;
  assign unused_rxd = rxd;
  assign rx_in      = txd_q;
`else
  assign rx_in      = rxd;
`endif

  // Divisors of 0 and 1 both collapse to a zero reload, i.e. en16 every cycle.
  function automatic logic [15:0] reload_val(input logic [15:0] div);
    return (div <= 16'd1) ? 16'd0 : div - 16'd1;
  endfunction

  assign en16 = (cnt_q == 16'd0);

  always_comb begin
    div_d = div_q;
    if (wr_dlo) div_d[7:0]  = databus;
    if (wr_dhi) div_d[15:8] = databus;
    if (wr_dlo || wr_dhi)   cnt_d = reload_val(div_d);
    else if (en16)          cnt_d = reload_val(div_q);
    else                    cnt_d = cnt_q - 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= DIV_RESET;
      cnt_q <= DIV_RESET - 16'd1;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    unique case (ioaddr)
      2'b00: rd_data = rx_buf_q;
      2'b01: rd_data = {4'b0000, ferr_q, ovr_q, rda_q, tbr_q};
      2'b10: rd_data = div_q[7:0];
      2'b11: rd_data = div_q[15:8];
    endcase
  end

  assign databus = rd_en ? rd_data : 8'bzzzz_zzzz;

  // Transmitter: tbr low means a byte is pending or in flight; the shifter doubles as the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= 4'd0;
      tx_bit_q   <= 3'd0;
      tbr_q      <= 1'b1;
      txd_q      <= 1'b1;
    end else begin
      if (wr_tx && tbr_q) begin
        tx_shift_q <= databus;
        tbr_q      <= 1'b0;
      end
      if (en16) begin
        unique case (tx_state_q)
          TX_IDLE: begin
            if (!tbr_q) begin
              tx_state_q <= TX_START;
              tx_tick_q  <= 4'd0;
              txd_q      <= 1'b0;
            end
          end
          TX_START: begin
            tx_tick_q <= tx_tick_q + 4'd1;
            if (tx_tick_q == 4'd15) begin
              tx_state_q <= TX_DATA;
              tx_bit_q   <= 3'd0;
              txd_q      <= tx_shift_q[0];
            end
          end
          TX_DATA: begin
            tx_tick_q <= tx_tick_q + 4'd1;
            if (tx_tick_q == 4'd15) begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_shift_q <= {1'b1, tx_shift_q[7:1]};
              if (tx_bit_q == 3'd7) begin
                tx_state_q <= TX_STOP;
                txd_q      <= 1'b1;
              end else begin
                txd_q      <= tx_shift_q[1];
              end
            end
          end
          TX_STOP: begin
            tx_tick_q <= tx_tick_q + 4'd1;
            if (tx_tick_q == 4'd15) begin
              tx_state_q <= TX_IDLE;
              tbr_q      <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Receiver: clears from bus reads come first so a same-cycle set event overrides them.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_tick_q  <= 4'd0;
      rx_bit_q   <= 3'd0;
      rx_buf_q   <= 8'h00;
      rda_q      <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_s1_q <= rx_in;
      rx_s2_q <= rx_s1_q;
      if (rd_rx) rda_q <= 1'b0;
      if (rd_st) begin
        ovr_q  <= 1'b0;
        ferr_q <= 1'b0;
      end
      unique case (rx_state_q)
        RX_IDLE: begin
          if (!rx_s2_q) begin
            rx_state_q <= RX_START;
            rx_tick_q  <= 4'd0;
          end
        end
        RX_START: begin
          if (en16) begin
            rx_tick_q <= rx_tick_q + 4'd1;
            if (rx_tick_q == 4'd7) begin
              rx_tick_q <= 4'd0;
              rx_bit_q  <= 3'd0;
              rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (en16) begin
            rx_tick_q <= rx_tick_q + 4'd1;
            if (rx_tick_q == 4'd15) begin
              rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
              rx_bit_q   <= rx_bit_q + 3'd1;
              if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            end
          end
        end
        RX_STOP: begin
          if (en16) begin
            rx_tick_q <= rx_tick_q + 4'd1;
            if (rx_tick_q == 4'd15) begin
              rx_state_q <= RX_IDLE;
              if (rx_s2_q) begin
                rx_buf_q <= rx_shift_q;
                rda_q    <= 1'b1;
                if (rda_q && !rd_rx) ovr_q <= 1'b1;
              end else begin
                ferr_q   <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  assign rda = rda_q;
  assign tbr = tbr_q;
  assign txd = txd_q;

endmodule

// File: tb/tb_spart_core.sv
// Scoreboard bench for spart_core: stimulus queues expectations, a negedge monitor checks bus reads and pin probes.
module tb_spart_core;
  logic       clk = 1'b0;
  logic       rst, iocs, iorw, rxd;
  logic [1:0] ioaddr;
  logic [7:0] bus_drv;
  logic       bus_oe;
  wire  [7:0] databus;
  logic       rda, tbr, txd;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  logic       probe;
  logic [1:0] probe_sel;
  logic       low_seen;

  assign databus = bus_oe ? bus_drv : 8'bzzzz_zzzz;
  always #5 clk = ~clk;

  spart_core #(.DIV_RESET(16'd1302)) dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
  );

  // Monitor: a bus read or a pin probe is an output event; pop and compare.
  always @(negedge clk) begin
    logic [7:0] act;
    exp_t       e;
    if ((iocs && iorw) || probe) begin
      if (iocs && iorw) act = databus;
      else begin
        case (probe_sel)
          2'd0:    act = {7'b0, txd};
          2'd1:    act = {7'b0, rda};
          2'd2:    act = {7'b0, tbr};
          default: act = {7'b0, low_seen};
        endcase
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output actual=%h required=none", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s actual=%h required=%h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string name, input logic [7:0] val);
    exp_t e;
    e.name = name;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; bus_drv = d; bus_oe = 1'b1;
    tick(1);
    iocs = 1'b0; bus_oe = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [7:0] exp, input string name);
    push_exp(name, exp);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    tick(1);
    iocs = 1'b0; iorw = 1'b0;
  endtask

  task automatic pin_chk(input logic [1:0] sel, input logic exp, input string name);
    push_exp(name, {7'b0, exp});
    probe = 1'b1; probe_sel = sel;
    tick(1);
    probe = 1'b0;
  endtask

  task automatic wait_txd_low(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!txd) begin
        found = 1'b1;
        break;
      end
      tick(1);
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s actual=no_start required=start_within_300", name);
    end
  endtask

  // One serial frame at 64 clocks per bit; stop_len shortens a bad stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_len);
    rxd = 1'b0;
    tick(64);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(64);
    end
    rxd = stop_bit;
    tick(stop_len);
    rxd = 1'b1;
    if (stop_len < 64) tick(64);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] frame;
    rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
    bus_drv = 8'h00; bus_oe = 1'b0; rxd = 1'b1; probe = 1'b0;
    probe_sel = 2'd0; low_seen = 1'b0;
    tick(3);
    rst = 1'b0;

    bus_read(2'b10, 8'h16, "reset_div_lo");
    bus_read(2'b11, 8'h05, "reset_div_hi");
    bus_read(2'b01, 8'h01, "reset_status");
    pin_chk(2'd0, 1'b1, "reset_txd");
    pin_chk(2'd1, 1'b0, "reset_rda");

    bus_write(2'b10, 8'h04);
    bus_write(2'b11, 8'h00);
    bus_read(2'b10, 8'h04, "div_lo_rb");
    bus_read(2'b11, 8'h00, "div_hi_rb");

    bus_write(2'b00, 8'h41);
    pin_chk(2'd2, 1'b0, "tbr_after_load");
    bus_write(2'b00, 8'h55);
    wait_txd_low("tx_start");
    frame = {1'b1, 8'h41, 1'b0};
    tick(31);
    pin_chk(2'd0, frame[0], "tx_bit0");
    for (int i = 1; i < 10; i++) begin
      tick(63);
      pin_chk(2'd0, frame[i], $sformatf("tx_bit%0d", i));
    end
    tick(40);
    pin_chk(2'd2, 1'b1, "tbr_after_stop");
    low_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (!txd) low_seen = 1'b1;
    end
    pin_chk(2'd3, 1'b0, "no_second_frame");

`ifdef SPART_LOOPBACK_EN
    bus_read(2'b00, 8'h41, "loop_first_byte");
    bus_write(2'b00, 8'h5A);
    tick(800);
    pin_chk(2'd1, 1'b1, "loop_rda");
    bus_read(2'b00, 8'h5A, "loop_byte");
    pin_chk(2'd1, 1'b0, "loop_rda_clear");
`else
    send_frame(8'hA3, 1'b1, 64);
    pin_chk(2'd1, 1'b1, "rx_rda_set");
    bus_read(2'b00, 8'hA3, "rx_byte");
    pin_chk(2'd1, 1'b0, "rx_rda_clear");

    send_frame(8'h11, 1'b1, 64);
    send_frame(8'h22, 1'b1, 64);
    bus_read(2'b01, 8'h07, "ovr_status");
    bus_read(2'b00, 8'h22, "ovr_byte");

    send_frame(8'h3C, 1'b0, 40);
    tick(100);
    bus_read(2'b01, 8'h09, "ferr_status");
    bus_read(2'b01, 8'h01, "status_cleared");

    rxd = 1'b0;
    tick(2);
    rxd = 1'b1;
    tick(700);
    bus_read(2'b01, 8'h01, "glitch_status");
    pin_chk(2'd1, 1'b0, "glitch_rda");
`endif

    bus_write(2'b00, 8'h96);
    wait_txd_low("tx_start_abort");
    tick(100);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    pin_chk(2'd0, 1'b1, "abort_txd");
    pin_chk(2'd2, 1'b1, "abort_tbr");
    bus_read(2'b10, 8'h16, "abort_div_lo");

    tick(5);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover_expectations actual=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
